// File: rtl/wb_burst_ram_pkg.sv
// Shared constants, FSM state type and burst address helper for wb_burst_ram.
package wb_burst_ram_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Widest word index the helper handles; callers zero-extend and truncate.
  localparam int IDX_MAX_W = 64;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // Wrapping bursts only advance the low log2(N) bits; upper bits stay fixed.
  function automatic logic [IDX_MAX_W-1:0] next_burst_idx(input logic [IDX_MAX_W-1:0] idx,
                                                         input logic [1:0]           bte);
    logic [IDX_MAX_W-1:0] nxt;
    nxt = idx;
    case (bte)
      BTE_WRAP4:  nxt[1:0] = idx[1:0] + 2'd1;
      BTE_WRAP8:  nxt[2:0] = idx[2:0] + 3'd1;
      BTE_WRAP16: nxt[3:0] = idx[3:0] + 4'd1;
      default:    nxt      = idx + 1'b1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wb_burst_ram_mem.sv
// DEPTH x DW single-port synchronous RAM with byte enables, read-first.
module wb_burst_ram_mem #(
  parameter int    DW      = 32,
  parameter int    DEPTH   = 8192,
  parameter string MEMFILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DW/8-1:0]          sel,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            q
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset -- a reset would prevent block-RAM mapping
  // and contents must survive a bus reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/wb_burst_ram.sv
// Wishbone B3 burst RAM slave with programmable first-access wait states.
// Define WB_BURST_RAM_ERR_EN to answer out-of-range indices with wb_err_o instead of aliasing.
module wb_burst_ram
  import wb_burst_ram_pkg::*;
#(
  parameter int    DW          = 32,
  parameter int    AW          = 32,
  parameter int    DEPTH       = 8192,
  parameter int    WAIT_STATES = 0,
  parameter string MEMFILE     = ""
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o
);

  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = $clog2(DEPTH);
  localparam int XW  = AW - LSB;

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_range
    $error("wb_burst_ram: WAIT_STATES must be in 0..15");
  end

  state_t               state;
  logic [3:0]           wait_cnt;
  logic [XW-1:0]        idx;
  logic [XW-1:0]        idx_next;
  logic [XW-1:0]        rd_idx;
  logic [IDX_MAX_W-1:0] idx_next_wide;
  logic                 ack_q;
  logic                 err_q;
  logic                 burst_go;
  logic                 beat_done;
  logic                 advance;
  logic                 rd_oor;
  logic                 mem_we;
  logic [IW-1:0]        mem_addr;
  logic [DW-1:0]        mem_q;
  logic                 unused_bits;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    burst_go = 1'b0;
    case (wb_cti_i)
      CTI_INC:              burst_go = 1'b1;
      CTI_CLASSIC, CTI_EOB: burst_go = 1'b0;
      default:              burst_go = 1'b0;
    endcase
  end

  assign idx_next_wide = next_burst_idx(IDX_MAX_W'(idx), wb_bte_i);
  assign idx_next      = idx_next_wide[XW-1:0];

  // A beat completes on the edge where our response meets a live strobe.
  assign beat_done = (ack_q | err_q) & wb_stb_i & wb_cyc_i;
  assign advance   = (state == ACK) & beat_done & burst_go;
  assign rd_idx    = advance ? idx_next : idx;
  assign mem_we    = (state == ACK) & ack_q & wb_stb_i & wb_cyc_i & wb_we_i;
  assign mem_addr  = mem_we ? idx[IW-1:0] : rd_idx[IW-1:0];

`ifdef WB_BURST_RAM_ERR_EN
  assign rd_oor      = |rd_idx[XW-1:IW];
  assign unused_bits = ^{wb_adr_i[LSB-1:0], idx_next_wide[IDX_MAX_W-1:XW]};
`else
  assign rd_oor      = 1'b0;
  assign unused_bits = ^{wb_adr_i[LSB-1:0], idx_next_wide[IDX_MAX_W-1:XW], rd_idx[XW-1:IW]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      idx      <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            idx      <= wb_adr_i[AW-1:LSB];
            wait_cnt <= 4'(WAIT_STATES);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (wb_stb_i) begin
            ack_q <= ~rd_oor;
            err_q <= rd_oor;
            state <= ACK;
          end
        end
        ACK: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (beat_done && !burst_go) begin
            state <= IDLE;
          end else if (wb_stb_i) begin
            // Either the next burst beat or a resume after a strobe gap: no wait states here.
            ack_q <= ~rd_oor;
            err_q <= rd_oor;
            if (beat_done) idx <= idx_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  wb_burst_ram_mem #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .MEMFILE (MEMFILE)
  ) u_mem (
    .clk   (wb_clk_i),
    .we    (mem_we),
    .sel   (wb_sel_i),
    .addr  (mem_addr),
    .wdata (wb_dat_i),
    .q     (mem_q)
  );

  assign wb_dat_o = ack_q ? mem_q : '0;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
